// File: rtl/iob_ibex_arb_pkg.sv
// Shared types and constants for the ibex instruction/data bus arbiter.
package iob_ibex_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/iob_ibex_arb_fifo.sv
// Owner FIFO: remembers which requester each outstanding downstream
// transaction belongs to so responses can be routed back in order.
module iob_ibex_arb_fifo
    import iob_ibex_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   cke_i,
    input  logic   arst_ni,
    input  logic   push_i,
    input  owner_e owner_i,
    input  logic   pop_i,
    output owner_e head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

    owner_e           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign empty_o   = (cnt_q == {CNT_W{1'b0}});
    assign full_o    = (cnt_q == DEPTH_C);
    assign head_o    = mem_q[rptr_q];
    // A pop at full frees the slot the simultaneous push lands in.
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and count; everything holds while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= OWN_DATA;
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else if (cke_i) begin
            if (do_push_s) begin
                mem_q[wptr_q] <= owner_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop_s) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iob_ibex_bus_arb.sv
// Arbitrates ibex instruction and data ports onto one downstream bus.
// Define IOB_IBEX_ARB_RR_EN for round-robin; default is data-over-instr priority.
module iob_ibex_bus_arb
    import iob_ibex_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_ni,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                m_req_o,
    output logic                m_we_o,
    output logic [DATA_W/8-1:0] m_be_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    input  logic                m_gnt_i,
    input  logic                m_rvalid_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_err_i
);

    localparam int unsigned BE_W = DATA_W / 8;

    owner_e owner_s;
    owner_e head_s;
    owner_e lock_owner_q;
    owner_e lock_owner_d;
    logic   lock_q;
    logic   lock_d;
    logic   owner_req_s;
    logic   fifo_full_s;
    logic   fifo_empty_s;
    logic   push_s;
    logic   pop_s;
`ifdef IOB_IBEX_ARB_RR_EN
    owner_e last_q;
    owner_e last_d;
`endif

    // Owner selection: a pending ungranted request keeps its owner.
    always_comb begin
        owner_s = OWN_DATA;
        if (lock_q) begin
            owner_s = lock_owner_q;
        end else if (data_req_i && instr_req_i) begin
`ifdef IOB_IBEX_ARB_RR_EN
            owner_s = (last_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
`else
            owner_s = OWN_DATA;
`endif
        end else if (instr_req_i) begin
            owner_s = OWN_INSTR;
        end else begin
            owner_s = OWN_DATA;
        end
    end

    assign owner_req_s = (owner_s == OWN_DATA) ? data_req_i : instr_req_i;
    assign m_req_o     = arst_ni & owner_req_s & (~fifo_full_s | m_rvalid_i);
    assign push_s      = m_req_o & m_gnt_i;
    assign pop_s       = m_rvalid_i & ~fifo_empty_s;

    assign instr_gnt_o    = push_s & (owner_s == OWN_INSTR);
    assign data_gnt_o     = push_s & (owner_s == OWN_DATA);
    assign instr_rvalid_o = pop_s & (head_s == OWN_INSTR);
    assign data_rvalid_o  = pop_s & (head_s == OWN_DATA);
    assign rsp_rdata_o    = m_rdata_i;
    assign rsp_err_o      = m_err_i;

    // Downstream request fields; fetches are full-word reads.
    always_comb begin
        m_we_o    = 1'b0;
        m_be_o    = {BE_W{1'b1}};
        m_addr_o  = instr_addr_i;
        m_wdata_o = {DATA_W{1'b0}};
        if (owner_s == OWN_DATA) begin
            m_we_o    = data_we_i;
            m_be_o    = data_be_i;
            m_addr_o  = data_addr_i;
            m_wdata_o = data_wdata_i;
        end else begin
            m_we_o    = 1'b0;
            m_be_o    = {BE_W{1'b1}};
            m_addr_o  = instr_addr_i;
            m_wdata_o = {DATA_W{1'b0}};
        end
    end

    // Lock next-state: held across cycles while the request waits for grant.
    always_comb begin
        lock_d       = m_req_o & ~m_gnt_i;
        lock_owner_d = owner_s;
    end

    // Lock registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_DATA;
        end else if (cke_i) begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

`ifdef IOB_IBEX_ARB_RR_EN
    // Round-robin pointer tracks the last granted owner.
    always_comb begin
        last_d = last_q;
        if (push_s) begin
            last_d = owner_s;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset value makes data win the first contest.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            last_q <= OWN_INSTR;
        end else if (cke_i) begin
            last_q <= last_d;
        end
    end
`endif

    iob_ibex_arb_fifo u_fifo (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_ni (arst_ni),
        .push_i  (push_s),
        .owner_i (owner_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

endmodule

// File: tb/tb_iob_ibex_bus_arb.sv
// Directed self-checking bench for iob_ibex_bus_arb (default and RR builds).
module tb_iob_ibex_bus_arb;

    logic        clk_i = 1'b0;
    logic        cke_i;
    logic        arst_ni;
    logic        instr_req_i;
    logic [29:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [29:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [29:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;
    logic        m_err_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    iob_ibex_bus_arb #(.ADDR_W(30), .DATA_W(32)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_ni(arst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
        .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i), .m_err_i(m_err_i)
    );

    task automatic idle();
        instr_req_i = 1'b0; instr_addr_i = 30'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 30'h0; data_wdata_i = 32'h0;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'h0; m_err_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        arst_ni = 1'b0;
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    task automatic test_reset();
        cke_i = 1'b1;
        idle();
        arst_ni = 1'b0;
        @(negedge clk_i);
        instr_req_i = 1'b1; data_req_i = 1'b1; m_gnt_i = 1'b1; m_rvalid_i = 1'b1;
        #1;
        checks++; if (m_req_o !== 1'b0) begin failures++; $display("FAIL rst_mreq got=%0h exp=0", m_req_o); end
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", {instr_gnt_o, data_gnt_o}); end
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk_i);
        idle();
        arst_ni = 1'b1;
    endtask

    task automatic test_instr_fetch();
        int gnt_cnt;
        gnt_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            idle();
            instr_req_i = 1'b1; instr_addr_i = 30'h100; m_gnt_i = (c == 2);
            #1;
            if (instr_gnt_o === 1'b1) gnt_cnt++;
            checks++; if (m_addr_o !== 30'h100 || m_req_o !== 1'b1) begin failures++; $display("FAIL fetch_addr c%0d got=%0h/%0h exp=100/1", c, m_addr_o, m_req_o); end
            checks++; if (m_be_o !== 4'hF || m_we_o !== 1'b0 || m_wdata_o !== 32'h0) begin failures++; $display("FAIL fetch_fields c%0d be=%0h we=%0h wd=%0h exp=f/0/0", c, m_be_o, m_we_o, m_wdata_o); end
        end
        checks++; if (gnt_cnt !== 1) begin failures++; $display("FAIL fetch_gnt_pulses got=%0d exp=1", gnt_cnt); end
        @(negedge clk_i);
        idle();
        m_rvalid_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin failures++; $display("FAIL fetch_rvalid got=%b exp=10", {instr_rvalid_o, data_rvalid_o}); end
        checks++; if (rsp_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata got=%0h exp=deadbeef", rsp_rdata_o); end
        @(negedge clk_i);
        idle();
        m_rvalid_i = 1'b1;
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL empty_rvalid got=%b exp=00", {instr_rvalid_o, data_rvalid_o}); end
    endtask

    task automatic test_lock();
        @(negedge clk_i);
        idle();
        instr_req_i = 1'b1; instr_addr_i = 30'h200;
        #1;
        checks++; if (m_addr_o !== 30'h200) begin failures++; $display("FAIL lock_c1_addr got=%0h exp=200", m_addr_o); end
        @(negedge clk_i);
        data_req_i = 1'b1; data_addr_i = 30'h300; data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'h1234;
        #1;
        checks++; if (m_addr_o !== 30'h200 || m_we_o !== 1'b0) begin failures++; $display("FAIL lock_hold got=%0h/%0h exp=200/0", m_addr_o, m_we_o); end
        @(negedge clk_i);
        m_gnt_i = 1'b1;
        #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10 || m_addr_o !== 30'h200) begin failures++; $display("FAIL lock_grant got=%b/%0h exp=10/200", {instr_gnt_o, data_gnt_o}, m_addr_o); end
        @(negedge clk_i);
        instr_req_i = 1'b0;
        #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin failures++; $display("FAIL lock_next_gnt got=%b exp=01", {instr_gnt_o, data_gnt_o}); end
        checks++; if (m_addr_o !== 30'h300 || m_we_o !== 1'b1 || m_be_o !== 4'h3 || m_wdata_o !== 32'h1234) begin failures++; $display("FAIL lock_data_fields got=%0h/%0h/%0h/%0h exp=300/1/3/1234", m_addr_o, m_we_o, m_be_o, m_wdata_o); end
        @(negedge clk_i);
        idle();
        m_rvalid_i = 1'b1;
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin failures++; $display("FAIL lock_rsp1 got=%b exp=10", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk_i);
        m_err_i = 1'b1;
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01 || rsp_err_o !== 1'b1) begin failures++; $display("FAIL lock_rsp2 got=%b/%0h exp=01/1", {instr_rvalid_o, data_rvalid_o}, rsp_err_o); end
    endtask

    task automatic test_priority();
        logic [1:0] exp;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            idle();
            instr_req_i = 1'b1; instr_addr_i = 30'h40; data_req_i = 1'b1; data_addr_i = 30'h80;
            m_gnt_i = 1'b1; m_rvalid_i = 1'b1;
            #1;
`ifdef IOB_IBEX_ARB_RR_EN
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp = 2'b01;
`endif
            checks++; if ({instr_gnt_o, data_gnt_o} !== exp) begin failures++; $display("FAIL prio c%0d got=%b exp=%b", c, {instr_gnt_o, data_gnt_o}, exp); end
        end
    endtask

    task automatic test_full();
        do_reset();
        @(negedge clk_i);
        idle();
        data_req_i = 1'b1; data_addr_i = 30'h10; m_gnt_i = 1'b1;
        #1;
        checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL full_push1 got=%0h exp=1", data_gnt_o); end
        @(negedge clk_i);
        data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 30'h20;
        #1;
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("FAIL full_push2 got=%0h exp=1", instr_gnt_o); end
        @(negedge clk_i);
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 30'h30;
        #1;
        checks++; if (m_req_o !== 1'b0 || data_gnt_o !== 1'b0) begin failures++; $display("FAIL full_block got=%0h/%0h exp=0/0", m_req_o, data_gnt_o); end
        @(negedge clk_i);
        m_rvalid_i = 1'b1; m_rdata_i = 32'h11;
        #1;
        checks++; if (m_req_o !== 1'b1 || data_gnt_o !== 1'b1) begin failures++; $display("FAIL full_pushpop got=%0h/%0h exp=1/1", m_req_o, data_gnt_o); end
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin failures++; $display("FAIL full_rsp1 got=%b exp=01", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk_i);
        data_req_i = 1'b0; m_gnt_i = 1'b0; m_rdata_i = 32'h22;
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin failures++; $display("FAIL full_rsp2 got=%b exp=10", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk_i);
        m_rdata_i = 32'h33;
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin failures++; $display("FAIL full_rsp3 got=%b exp=01", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk_i);
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL full_drained got=%b exp=00", {instr_rvalid_o, data_rvalid_o}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk_i);
        idle();
        data_req_i = 1'b1; m_gnt_i = 1'b1;
        @(negedge clk_i);
        data_req_i = 1'b0; instr_req_i = 1'b1;
        @(negedge clk_i);
        arst_ni = 1'b0;
        #1;
        checks++; if (m_req_o !== 1'b0 || instr_gnt_o !== 1'b0) begin failures++; $display("FAIL midrst_out got=%0h/%0h exp=0/0", m_req_o, instr_gnt_o); end
        @(negedge clk_i);
        idle();
        arst_ni = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            idle();
            m_rvalid_i = 1'b1;
            #1;
            checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL midrst_drop c%0d got=%b exp=00", c, {instr_rvalid_o, data_rvalid_o}); end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            idle();
            data_req_i = 1'b1; m_gnt_i = 1'b1;
            #1;
            checks++; if (data_gnt_o !== (c < 2)) begin failures++; $display("FAIL midrst_empty c%0d got=%0h exp=%0h", c, data_gnt_o, (c < 2)); end
        end
    endtask

    task automatic test_cke_hold();
        do_reset();
        @(negedge clk_i);
        idle();
        cke_i = 1'b0; data_req_i = 1'b1; m_gnt_i = 1'b1;
        #1;
        checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL cke_comb_gnt got=%0h exp=1", data_gnt_o); end
        @(negedge clk_i);
        idle();
        cke_i = 1'b1; m_rvalid_i = 1'b1;
        #1;
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL cke_no_push got=%b exp=00", {instr_rvalid_o, data_rvalid_o}); end
        @(negedge clk_i);
        idle();
    endtask

    initial begin
        test_reset();
        test_instr_fetch();
        test_lock();
        test_priority();
        test_full();
        test_reset_mid();
        test_cke_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_ibex_bus_arb.md
IOB_IBEX_BUS_ARB -- requirements
Module: iob_ibex_bus_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port cke_i  input  1  clock enable; all registers hold when low.
REQ-005 SHALL have port arst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port instr_req_i  input  1  instruction fetch request.
REQ-007 SHALL have port instr_addr_i  input  ADDR_W  fetch word address.
REQ-008 SHALL have port instr_gnt_o  output  1  fetch request accepted.
REQ-009 SHALL have port instr_rvalid_o  output  1  fetch response valid.
REQ-010 SHALL have port data_req_i  input  1  load/store request.
REQ-011 SHALL have port data_we_i  input  1  1 = write.
REQ-012 SHALL have port data_be_i  input  DATA_W/8  byte enables.
REQ-013 SHALL have port data_addr_i  input  ADDR_W  load/store word address.
REQ-014 SHALL have port data_wdata_i  input  DATA_W  write data.
REQ-015 SHALL have port data_gnt_o  output  1  load/store request accepted.
REQ-016 SHALL have port data_rvalid_o  output  1  load/store response valid.
REQ-017 SHALL have port rsp_rdata_o  output  DATA_W  response data, shared by both requesters.
REQ-018 SHALL have port rsp_err_o  output  1  response error, shared by both requesters.
REQ-019 SHALL have port m_req_o  output  1  request to the shared downstream ibex-to-AXI bridge.
REQ-020 SHALL have port m_we_o  output  1  forwarded write enable; 0 for fetches.
REQ-021 SHALL have port m_be_o  output  DATA_W/8  forwarded byte enables; all-ones for fetches.
REQ-022 SHALL have port m_addr_o  output  ADDR_W  forwarded address.
REQ-023 SHALL have port m_wdata_o  output  DATA_W  forwarded write data; 0 for fetches.
REQ-024 SHALL have port m_gnt_i  input  1  downstream grant.
REQ-025 SHALL have port m_rvalid_i  input  1  downstream response valid.
REQ-026 SHALL have port m_rdata_i  input  DATA_W  downstream read data.
REQ-027 SHALL have port m_err_i  input  1  downstream error.

Function
REQ-028 SHALL select an owner combinationally when unlocked, with a 0-cycle path from req_i to m_req_o; m_req_o = owner request AND owner FIFO not full.
REQ-029 SHALL lock the owner while m_req_o=1 and m_gnt_i=0, and SHALL NOT switch owner until the grant arrives, even if the other requester asserts.
REQ-030 SHALL drive X_gnt_o = m_req_o AND m_gnt_i AND owner==X in the same cycle; the non-owner gnt SHALL be 0.
REQ-031 SHALL push the owner ID into a 2-entry owner FIFO on m_req_o AND m_gnt_i; at most 2 responses outstanding.
REQ-032 SHALL deassert m_req_o when the FIFO is full, except when m_rvalid_i pops in the same cycle; simultaneous push and pop at full is allowed and the count stays 2.
REQ-033 SHALL pop the FIFO head on m_rvalid_i and assert rvalid only toward the head owner; rsp_rdata_o and rsp_err_o SHALL pass through from m_rdata_i and m_err_i combinationally.
REQ-034 SHALL ignore m_rvalid_i when the FIFO is empty: no rvalid is asserted and the FIFO does not underflow.
REQ-035 SHALL hold the FIFO, lock and arbitration pointer when cke_i=0; combinational outputs still follow the inputs.

Reset
REQ-036 SHALL, while arst_ni=0, drive m_req_o, both gnt_o and both rvalid_o to 0, empty the FIFO, clear the lock and set the pointer to favour data.
REQ-037 SHALL, on reset in mid-operation, discard all outstanding owners; responses arriving after release SHALL be dropped per REQ-034.

Configuration
REQ-038 SHALL, with IOB_IBEX_ARB_RR_EN defined, use round-robin: on a contested unlocked cycle, grant the requester not granted last; the pointer updates on each push.
REQ-039 SHALL, without IOB_IBEX_ARB_RR_EN, use fixed priority with data over instr; the pointer register is not built.

Structure
REQ-040 SHALL place the owner enum (OWN_INSTR=0, OWN_DATA=1) and the FIFO depth constant (2) in the shared package iob_ibex_arb_pkg.
REQ-041 SHALL implement the owner FIFO as the sub-module iob_ibex_arb_fifo.

Verification
REQ-042 Instr-only fetch at 0x100, gnt after 2 cycles -> m_addr_o held at 0x100 for 3 cycles, m_be_o=0xF, instr_gnt_o pulses once, rvalid routed to instr.
REQ-043 Instr request locked, data_req_i rises before m_gnt_i -> owner stays instr until grant; data is granted on the next cycle.
REQ-044 Both requesting continuously, m_gnt_i=1 -> with RR_EN grants alternate D,I,D,I; without RR_EN only data is granted.
REQ-045 Two grants outstanding with a third request pending -> m_req_o=0; m_rvalid_i with push in the same cycle -> count stays 2 and responses return in order.
REQ-046 arst_ni pulsed low with 2 outstanding, then 2 m_rvalid_i -> no rvalid_o is asserted and the FIFO remains empty.
